// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types for the memory stage
package pipeline_pkg;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  typedef enum logic [2:0] {
    EXN_UDF      = 3'd0,
    EXN_SCALL    = 3'd1,
    EXN_ERET     = 3'd2,
    EXN_MISALIGN = 3'd3,
    EXN_BUS      = 3'd4
  } exn_cause_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [4:0]  rd;
    logic        w_rd;
    logic        w_cr;
    logic [1:0]  cmp_res;
    logic [31:0] alu_res;
    logic [31:0] op3;
    logic        mem_r;
    logic        mem_w;
    logic        io_r;
    logic        io_w;
    logic [1:0]  mem_sz;
    logic        mem_sx;
    logic        link;
    logic        mfcr;
    logic        mfsr;
    logic        mtsr;
    logic        udf;
    logic        scall;
    logic        eret;
    logic        bubble;
  } ex_out_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        w_rd;
    logic [31:0] res;
    logic        w_cr;
    logic [1:0]  cmp_res;
    logic        bubble;
  } mem_out_t;

  function automatic logic is_access(ex_out_t e);
    return e.mem_r | e.mem_w | e.io_r | e.io_w;
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte enables, misalignment check and load lane extract/extend
module mem_align (
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sx_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic        misaligned_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o         = 4'b1111;
    misaligned_o = 1'b0;
    load_data_o  = rdata_i;
    case (size_i)
      2'd0: begin
        be_o        = 4'b0001 << addr_lo_i;
        load_data_o = {{24{sx_i & byte_v[7]}}, byte_v};
      end
      2'd1: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misaligned_o = addr_lo_i[0];
        load_data_o  = {{16{sx_i & half_v[15]}}, half_v};
      end
      default: begin
        misaligned_o = (addr_lo_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - memory stage: stage register, req/ack data bus FSM, result select, exceptions
import pipeline_pkg::*;

module stage_mem #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  ex_out_t     EX,
  output mem_out_t    out,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        dmem_io,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  cr,
  output logic [4:0]  sr_addr,
  input  logic [31:0] sr_rdata,
  output logic        sr_we,
  output logic        exn,
  output logic [2:0]  exn_cause,
  output logic [31:0] exn_pc
);

  ex_out_t     stage_q;
  mem_state_t  state_q, state_d;
  logic [31:0] timer_q, timer_d;

  logic        valid, access, misaligned, instr_exn, mem, timeout, load_hit;
  logic [31:0] load_data;

  mem_align u_align (
    .addr_lo_i    (stage_q.alu_res[1:0]),
    .size_i       (stage_q.mem_sz),
    .sx_i         (stage_q.mem_sx),
    .rdata_i      (dmem_rdata),
    .be_o         (dmem_be),
    .misaligned_o (misaligned),
    .load_data_o  (load_data)
  );

  assign valid     = !stage_q.bubble;
  assign access    = is_access(stage_q);
  assign instr_exn = valid && (stage_q.udf || stage_q.scall || stage_q.eret || (access && misaligned));
  assign mem       = access && valid && !instr_exn;
  // A zero timeout disables the bus-error watchdog entirely.
  assign timeout   = (ACK_TIMEOUT != 0) && (state_q == WAIT) && (timer_q >= 32'(ACK_TIMEOUT));

  assign dmem_req   = mem && !timeout;
  assign stall      = dmem_req && !dmem_ack;
  assign dmem_we    = dmem_req && (stage_q.mem_w || stage_q.io_w);
  assign dmem_io    = stage_q.io_r || stage_q.io_w;
  assign dmem_addr  = {stage_q.alu_res[31:2], 2'b00};
  assign dmem_wdata = stage_q.op3;
  assign load_hit   = dmem_req && dmem_ack && (stage_q.mem_r || stage_q.io_r);

  assign exn     = instr_exn || timeout;
  assign exn_pc  = stage_q.pc;
  assign sr_addr = stage_q.alu_res[4:0];
  assign sr_we   = stage_q.mtsr && valid && !exn;

  always_comb begin
    if (stage_q.udf)                exn_cause = EXN_UDF;
    else if (access && misaligned)  exn_cause = EXN_MISALIGN;
    else if (stage_q.scall)         exn_cause = EXN_SCALL;
    else if (stage_q.eret)          exn_cause = EXN_ERET;
    else                            exn_cause = EXN_BUS;
  end

  always_comb begin
    out.pc      = stage_q.pc;
    out.rd      = stage_q.rd;
    out.cmp_res = stage_q.cmp_res;
    out.w_rd    = stage_q.w_rd && valid && !exn && !stall;
    out.w_cr    = stage_q.w_cr && valid && !exn && !stall;
    out.bubble  = stage_q.bubble || stall || exn;
    if (load_hit)          out.res = load_data;
    else if (stage_q.link) out.res = stage_q.nextpc;
    else if (stage_q.mfcr) out.res = {30'b0, cr};
    else if (stage_q.mfsr) out.res = sr_rdata;
    else                   out.res = stage_q.alu_res;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (mem && !dmem_ack) begin
          state_d = WAIT;
          timer_d = 32'd1;
        end
      end
      default: begin
        if (timeout || dmem_ack) begin
          state_d = IDLE;
          timer_d = 32'd0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stage_q        <= '0;
      stage_q.bubble <= 1'b1;
      state_q        <= IDLE;
      timer_q        <= 32'd0;
    end else begin
      if (!stall) stage_q <= EX;
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// tb/tb_stage_mem.sv - table-driven scoreboard bench for stage_mem (ACK_TIMEOUT=4)
module tb_stage_mem;
  import pipeline_pkg::*;

  localparam int TO = 4;

  typedef struct {
    string       name;
    logic [31:0] pc, a, npc, op3, rdata;
    logic [1:0]  sz;
    logic        sx, mr, mw, io, wrd, udf, scall, eret, link, mfcr, mfsr, mtsr;
    int          ack_dly, exp_req, exp_stall;
    logic [3:0]  exp_be;
    logic [31:0] exp_res;
    logic        exp_wrd, exp_exn, exp_srwe;
    logic [2:0]  exp_cause;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  ex_out_t     ex;
  mem_out_t    out_s;
  logic        stall, dmem_req, dmem_we, dmem_io, sr_we, exn;
  logic [31:0] dmem_addr, dmem_wdata, exn_pc;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic [1:0]  cr = 2'b10;
  logic [4:0]  sr_addr;
  logic [31:0] sr_rdata = 32'hCAFEF00D;
  logic [2:0]  exn_cause;

  int n_chk = 0;
  int n_fail = 0;
  vec_t vs[$];
  vec_t sb[$];

  stage_mem #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .EX(ex), .out(out_s), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_io(dmem_io), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .cr(cr), .sr_addr(sr_addr), .sr_rdata(sr_rdata), .sr_we(sr_we),
    .exn(exn), .exn_cause(exn_cause), .exn_pc(exn_pc)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic ex_out_t bubble_ex();
    ex_out_t e;
    e = '0;
    e.bubble = 1'b1;
    return e;
  endfunction

  function automatic ex_out_t to_ex(vec_t v);
    ex_out_t e;
    e = '0;
    e.pc = v.pc;        e.nextpc = v.npc;   e.rd = 5'd7;     e.w_rd = v.wrd;
    e.alu_res = v.a;    e.op3 = v.op3;      e.mem_sz = v.sz; e.mem_sx = v.sx;
    e.mem_r = v.mr & ~v.io;  e.io_r = v.mr & v.io;
    e.mem_w = v.mw & ~v.io;  e.io_w = v.mw & v.io;
    e.udf = v.udf;   e.scall = v.scall; e.eret = v.eret; e.link = v.link;
    e.mfcr = v.mfcr; e.mfsr = v.mfsr;   e.mtsr = v.mtsr;
    return e;
  endfunction

  function automatic vec_t nop(string n, logic [31:0] a);
    vec_t v;
    v.name = n; v.pc = 32'h0; v.a = a; v.npc = 32'h0BAD0000; v.op3 = 32'h0; v.rdata = 32'h0;
    v.sz = 2'd2; v.sx = 1'b0; v.mr = 1'b0; v.mw = 1'b0; v.io = 1'b0; v.wrd = 1'b1;
    v.udf = 1'b0; v.scall = 1'b0; v.eret = 1'b0; v.link = 1'b0; v.mfcr = 1'b0; v.mfsr = 1'b0; v.mtsr = 1'b0;
    v.ack_dly = 0; v.exp_req = 0; v.exp_stall = 0; v.exp_be = 4'h0;
    v.exp_res = a; v.exp_wrd = 1'b1; v.exp_exn = 1'b0; v.exp_srwe = 1'b0; v.exp_cause = 3'd0;
    return v;
  endfunction

  // Expected bus behaviour for an aligned access: ack on cycle dly, or bus error after TO cycles.
  function automatic vec_t bus_timing(vec_t v_in, int dly);
    vec_t v;
    v = v_in;
    v.ack_dly = dly;
    if (dly >= TO) begin
      v.exp_req = TO; v.exp_stall = TO; v.exp_res = v.a;
      v.exp_wrd = 1'b0; v.exp_exn = 1'b1; v.exp_cause = 3'd4;
    end else begin
      v.exp_req = dly + 1; v.exp_stall = dly;
    end
    return v;
  endfunction

  function automatic vec_t ld(string n, logic [31:0] a, logic [1:0] sz, logic sx, logic io,
                              logic [31:0] rd, int dly, logic [3:0] be, logic [31:0] res);
    vec_t v;
    v = nop(n, a);
    v.mr = 1'b1; v.sz = sz; v.sx = sx; v.io = io; v.rdata = rd;
    v.exp_be = be; v.exp_res = res;
    return bus_timing(v, dly);
  endfunction

  function automatic vec_t st(string n, logic [31:0] a, logic [1:0] sz, logic [31:0] d, int dly, logic [3:0] be);
    vec_t v;
    v = nop(n, a);
    v.mw = 1'b1; v.sz = sz; v.op3 = d; v.wrd = 1'b0; v.exp_wrd = 1'b0; v.exp_be = be;
    return bus_timing(v, dly);
  endfunction

  function automatic vec_t mis(vec_t v_in);
    vec_t v;
    v = v_in;
    v.exp_req = 0; v.exp_stall = 0; v.exp_res = v.a; v.exp_wrd = 1'b0;
    v.exp_exn = 1'b1; v.exp_cause = 3'd3;
    return v;
  endfunction

  task automatic run_vec(vec_t v_in, int idx);
    vec_t v, e;
    int   req_n, stall_n;
    bit   done;
    logic [3:0]  be_s;
    logic        we_s, io_s;
    logic [31:0] addr_s, wd_s;
    req_n = 0; stall_n = 0; done = 1'b0;
    be_s = 4'h0; we_s = 1'b0; io_s = 1'b0; addr_s = 32'h0; wd_s = 32'h0;
    v = v_in;
    v.pc = 32'h1000 + 32'(idx) * 32'd8;
    @(negedge clk);
    ex = to_ex(v);
    dmem_ack = 1'b0;
    sb.push_back(v);
    @(posedge clk);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      ex = bubble_ex();
      dmem_ack = (k == v.ack_dly);
      dmem_rdata = v.rdata;
      #1;
      if (dmem_req) begin
        req_n++;
        be_s = dmem_be; we_s = dmem_we; io_s = dmem_io; addr_s = dmem_addr; wd_s = dmem_wdata;
      end
      if (stall) stall_n++;
      else begin
        done = 1'b1;
        e = sb.pop_front();
        check({e.name, ".res"},   out_s.res, e.exp_res);
        check({e.name, ".w_rd"},  32'(out_s.w_rd), 32'(e.exp_wrd));
        check({e.name, ".exn"},   32'(exn), 32'(e.exp_exn));
        check({e.name, ".sr_we"}, 32'(sr_we), 32'(e.exp_srwe));
        check({e.name, ".req_cycles"},   32'(req_n), 32'(e.exp_req));
        check({e.name, ".stall_cycles"}, 32'(stall_n), 32'(e.exp_stall));
        if (e.exp_exn) begin
          check({e.name, ".cause"},  32'(exn_cause), 32'(e.exp_cause));
          check({e.name, ".exn_pc"}, exn_pc, e.pc);
        end
        if (e.exp_req > 0) begin
          check({e.name, ".be"},   32'(be_s), 32'(e.exp_be));
          check({e.name, ".we"},   32'(we_s), 32'(e.mw));
          check({e.name, ".io"},   32'(io_s), 32'(e.io));
          check({e.name, ".addr"}, addr_s, {e.a[31:2], 2'b00});
          if (e.mw) check({e.name, ".wdata"}, wd_s, e.op3);
        end
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL %s.complete: stall still 1 after 20 cycles, expected release", v.name);
      sb.delete();
    end
  endtask

  initial begin : main
    vec_t v;
    ex = bubble_ex();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset.req",    32'(dmem_req), 32'd0);
    check("reset.stall",  32'(stall), 32'd0);
    check("reset.exn",    32'(exn), 32'd0);
    check("reset.sr_we",  32'(sr_we), 32'd0);
    check("reset.res",    out_s.res, 32'd0);
    check("reset.bubble", 32'(out_s.bubble), 32'd1);
    check("reset.w_rd",   32'(out_s.w_rd), 32'd0);
    check("reset.w_cr",   32'(out_s.w_cr), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    vs.push_back(ld("lw_wait3", 32'h100, 2'd2, 1'b0, 1'b0, 32'hDEADBEEF, 3, 4'hF, 32'hDEADBEEF));
    vs.push_back(ld("lb_sx",    32'h103, 2'd0, 1'b1, 1'b0, 32'h80123456, 1, 4'h8, 32'hFFFFFF80));
    vs.push_back(ld("lbu",      32'h103, 2'd0, 1'b0, 1'b0, 32'h80123456, 0, 4'h8, 32'h00000080));
    vs.push_back(ld("lh_sx",    32'h102, 2'd1, 1'b1, 1'b0, 32'h8001ABCD, 2, 4'hC, 32'hFFFF8001));
    vs.push_back(ld("lhu",      32'h100, 2'd1, 1'b0, 1'b0, 32'h1234F00D, 0, 4'h3, 32'h0000F00D));
    vs.push_back(ld("lb_lane1", 32'h101, 2'd0, 1'b1, 1'b0, 32'h00007F00, 0, 4'h2, 32'h0000007F));
    vs.push_back(ld("io_lw",    32'h040, 2'd2, 1'b0, 1'b1, 32'h0BADCAFE, 1, 4'hF, 32'h0BADCAFE));
    vs.push_back(ld("lw_tmo",   32'h200, 2'd2, 1'b0, 1'b0, 32'h0, 1000, 4'hF, 32'h0));
    vs.push_back(st("sh_same",  32'h102, 2'd1, 32'h12341234, 0, 4'hC));
    vs.push_back(st("sb_wait2", 32'h101, 2'd0, 32'hA5A5A5A5, 2, 4'h2));
    vs.push_back(mis(ld("lw_mis", 32'h101, 2'd2, 1'b0, 1'b0, 32'h0, 0, 4'hF, 32'h0)));
    vs.push_back(mis(st("sh_mis", 32'h101, 2'd1, 32'h5555AAAA, 0, 4'hC)));
    v = mis(ld("udf_mis", 32'h101, 2'd2, 1'b0, 1'b0, 32'h0, 0, 4'hF, 32'h0));
    v.udf = 1'b1; v.exp_cause = 3'd0; vs.push_back(v);
    v = nop("udf", 32'h11);   v.udf = 1'b1;   v.exp_wrd = 1'b0; v.exp_exn = 1'b1; v.exp_cause = 3'd0; vs.push_back(v);
    v = nop("scall", 32'h12); v.scall = 1'b1; v.exp_wrd = 1'b0; v.exp_exn = 1'b1; v.exp_cause = 3'd1; vs.push_back(v);
    v = nop("eret", 32'h13);  v.eret = 1'b1;  v.exp_wrd = 1'b0; v.exp_exn = 1'b1; v.exp_cause = 3'd2; vs.push_back(v);
    v = nop("link", 32'h14);  v.link = 1'b1;  v.npc = 32'h00002004; v.exp_res = 32'h00002004; vs.push_back(v);
    v = nop("mfcr", 32'h15);  v.mfcr = 1'b1;  v.exp_res = 32'h00000002; vs.push_back(v);
    v = nop("mfsr", 32'h03);  v.mfsr = 1'b1;  v.exp_res = 32'hCAFEF00D; vs.push_back(v);
    v = nop("mtsr", 32'h05);  v.mtsr = 1'b1;  v.wrd = 1'b0; v.exp_wrd = 1'b0; v.exp_srwe = 1'b1; vs.push_back(v);
    v = nop("mtsr_udf", 32'h06); v.mtsr = 1'b1; v.udf = 1'b1; v.wrd = 1'b0; v.exp_wrd = 1'b0;
    v.exp_exn = 1'b1; v.exp_cause = 3'd0; vs.push_back(v);
    vs.push_back(nop("alu", 32'h00000055));

    for (int i = 0; i < vs.size(); i++) run_vec(vs[i], i);

    // Reset in the middle of a WAIT; the ack arriving afterwards must be ignored.
    v = ld("rst_mid", 32'h300, 2'd2, 1'b0, 1'b0, 32'h0, 1000, 4'hF, 32'h0);
    @(negedge clk);
    ex = to_ex(v); dmem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ex = bubble_ex(); #1;
    check("rst_mid.req_idle", 32'(dmem_req), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0; #1;
    check("rst_mid.req_wait",   32'(dmem_req), 32'd1);
    check("rst_mid.stall_wait", 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h11111111; #1;
    check("rst_mid.req_after",   32'(dmem_req), 32'd0);
    check("rst_mid.stall_after", 32'(stall), 32'd0);
    check("rst_mid.bubble",      32'(out_s.bubble), 32'd1);
    check("rst_mid.w_rd",        32'(out_s.w_rd), 32'd0);
    check("rst_mid.res",         out_s.res, 32'd0);
    check("rst_mid.exn",         32'(exn), 32'd0);
    @(posedge clk);
    @(negedge clk);
    dmem_ack = 1'b0; #1;
    check("rst_mid.req_later",   32'(dmem_req), 32'd0);
    check("rst_mid.stall_later", 32'(stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
